// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states and op classification.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpShl  = 4'h2,
    OpShr  = 4'h3,
    OpAnd  = 4'h4,
    OpOr   = 4'h5,
    OpXor  = 4'h6,
    OpNor  = 4'h7,
    OpNand = 4'h8,
    OpNot  = 4'h9,
    OpJr   = 4'hA,
    OpSlt  = 4'hB,
    OpSgt  = 4'hC,
    OpMul  = 4'hD,
    OpDivu = 4'hE,
    OpRemu = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  localparam int unsigned CntW = 6;

  function automatic logic is_multicycle(alu_op_t op);
    return (op == OpMul) || (op == OpDivu) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  alu_op_t      op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         done,
  output logic [N-1:0] result,
  output logic         dbz
);

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  alu_op_t         op_q;
  // acc: product accumulator / partial remainder; opa: multiplicand / dividend-quotient
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    opa_q, opa_d;
  logic [N-1:0]    opb_q, opb_d;
  logic            dbz_q;

  logic [N:0]      rem_sh;
  logic [N-1:0]    rem_sub;
  logic            rem_ge;

  always_comb begin
    rem_sh  = {acc_q, opa_q[N-1]};
    rem_ge  = rem_sh >= {1'b0, opb_q};
    // Only used when rem_ge, where the true difference is below 2^N.
    rem_sub = rem_sh[N-1:0] - opb_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    if (op_q == OpMul) begin
      if (opb_q[0]) acc_d = acc_q + opa_q;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end else begin
      acc_d = rem_ge ? rem_sub : rem_sh[N-1:0];
      opa_d = {opa_q[N-2:0], rem_ge};
    end
  end

  // Final step is taken combinationally so the top can register it on the cnt==0 edge.
  assign done   = busy_q && (cnt_q == '0);
  assign result = (op_q == OpDivu) ? opa_d : acc_d;
  assign dbz    = dbz_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OpMul;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CntW'(N - 1);
      op_q   <= op;
      acc_q  <= '0;
      opa_q  <= A;
      opb_q  <= B;
      dbz_q  <= (op != OpMul) && (B == '0);
    end else if (busy_q) begin
      acc_q  <= acc_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      cnt_q  <= done ? '0 : cnt_q - CntW'(1);
      busy_q <= !done;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops plus iterative mul/div/rem.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   aluControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         dbz
);

  localparam int unsigned SHW = $clog2(N);

  alu_state_t   state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic         zero_q;
  logic         dbz_q, dbz_d;

  alu_op_t      op;
  logic [N-1:0] simple;
  logic         accept;
  logic         multi;
  logic         it_done, it_dbz;
  logic [N-1:0] it_result;

  assign op     = alu_op_t'(aluControl);
  assign multi  = is_multicycle(op);
  assign accept = in_valid && in_ready;

  always_comb begin
    unique case (op)
      OpAdd, OpJr: simple = A + B;
      OpSub:       simple = A - B;
      OpShl:       simple = A << B[SHW-1:0];
      OpShr:       simple = A >> B[SHW-1:0];
      OpAnd:       simple = A & B;
      OpOr:        simple = A | B;
      OpXor:       simple = A ^ B;
      OpNor:       simple = ~(A | B);
      OpNand:      simple = ~(A & B);
      OpNot:       simple = ~A;
      OpSlt:       simple = {{(N-1){1'b0}}, $signed(A) < $signed(B)};
      OpSgt:       simple = {{(N-1){1'b0}}, $signed(A) > $signed(B)};
      default:     simple = '0;
    endcase
  end

  alu_muldiv_iter #(
    .N(N)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && multi),
    .op     (op),
    .A      (A),
    .B      (B),
    .done   (it_done),
    .result (it_result),
    .dbz    (it_dbz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = multi ? BUSY : DONE;
        end else if ((state_q == IDLE) || out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY:    if (it_done) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    dbz_d    = dbz_q;
    if (accept && !multi) begin
      result_d = simple;
      dbz_d    = 1'b0;
    end else if ((state_q == BUSY) && it_done) begin
      result_d = it_result;
      dbz_d    = it_dbz;
    end
  end

  // A result being taken frees the slot in the same cycle.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign dbz    = dbz_q;

endmodule
